// File: rtl/button_debounce_pulse.sv
`timescale 1ns/1ps
// button_debounce_pulse
//   Conditions one raw pushbutton for the seven-segment counter. The raw
//   input is brought into the clock domain through a two-flop synchronizer.
//   A debounce FSM then accepts a level change only after the synchronized
//   value has been stable long enough. The FSM emits a clean level, a
//   one-cycle press pulse with optional auto-repeat while the button is
//   held, and a one-cycle release pulse.
//
// Ports
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset (release synchronously)
//   btn_raw_i      raw pushbutton, asynchronous, active high
//   repeat_en_i    auto-repeat enable, quasi-static
//   btn_level_o    debounced level (registered)
//   btn_pulse_o    one-cycle pulse on accepted press and on each repeat
//   btn_release_o  one-cycle pulse on accepted release
module button_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 50000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000,
  parameter int CNT_WIDTH           = 26
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic btn_raw_i,
  input  logic repeat_en_i,
  output logic btn_level_o,
  output logic btn_pulse_o,
  output logic btn_release_o
);

  localparam logic [CNT_WIDTH-1:0] DEB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARM_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    ARM_RELEASE = 3'd4
  } state_t;

  logic                 btn_p0;
  logic                 btn_p1;
  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 level_d;
  logic                 pulse_d;
  logic                 release_d;

  // Stage p0/p1: two-flop synchronizer; btn_p1 is the only view of the
  // button that the FSM ever uses.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_raw_i;
      btn_p1 <= btn_p0;
    end
  end

  // Stage p2: debounce / repeat FSM next-state logic. The branch order
  // gives a change of the synchronized button priority over a change of
  // repeat_en_i, and a change of repeat_en_i priority over counter expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_p1) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!btn_p1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_p1) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end else if (repeat_en_i) begin
          if (cnt_q == DELAY_LAST) begin
            state_d = REPEAT;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Repeat disabled: the delay does not start until it is enabled.
          cnt_d = '0;
        end
      end
      REPEAT: begin
        if (!btn_p1) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end else if (!repeat_en_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == RATE_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ARM_RELEASE: begin
        if (btn_p1) begin
          // Short low glitch while held: back to HELD and restart the delay.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // The level follows the state being entered, so it rises together with
    // the press pulse and falls together with the release pulse.
    level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == ARM_RELEASE);
  end

  // Stage p2 register: FSM state, shared counter and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_level_o   <= 1'b0;
      btn_pulse_o   <= 1'b0;
      btn_release_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level_o   <= level_d;
      btn_pulse_o   <= pulse_d;
      btn_release_o <= release_d;
    end
  end

endmodule

// File: tb/tb_button_debounce_pulse.sv
`timescale 1ns/1ps
module tb_button_debounce_pulse;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw = 1'b0;
  logic en = 1'b0;
  logic level, pulse, rel;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES    (D),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR),
    .CNT_WIDTH          (CW)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .btn_raw_i    (raw),
    .repeat_en_i  (en),
    .btn_level_o  (level),
    .btn_pulse_o  (pulse),
    .btn_release_o(rel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: the button seen by the decision logic is the raw
  // input two edges late. A level change is accepted once the delayed
  // button has disagreed with the level on D+1 consecutive edges. While
  // held with repeat enabled, pulses come RD edges after the press (or
  // after any restart), then every RR edges.
  logic h1, h2, ms;
  logic m_level, m_pulse, m_rel;
  int   run, since;
  logic repeating;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1 = 0; h2 = 0; ms = 0;
      m_level = 0; m_pulse = 0; m_rel = 0;
      run = 0; since = 0; repeating = 0;
    end else begin
      ms = h2; h2 = h1; h1 = raw;
      m_pulse = 0; m_rel = 0;
      if (!m_level) begin
        if (ms) begin
          run++;
          if (run == D + 1) begin
            m_level = 1; m_pulse = 1; run = 0; since = 0; repeating = 0;
          end
        end else begin
          run = 0;
        end
      end else if (!ms) begin
        run++;
        if (run == D + 1) begin
          m_level = 0; m_rel = 1; run = 0;
        end
      end else if (run > 0) begin
        run = 0; since = 0; repeating = 0;
      end else if (!en) begin
        since = 0; repeating = 0;
      end else begin
        since++;
        if (since == (repeating ? RR : RD)) begin
          m_pulse = 1; repeating = 1; since = 0;
        end
      end
    end
  end

  int   pulse_q[$];
  int   rel_q[$];
  int   rise_q[$];
  logic prev_level = 1'b0;

  always @(negedge clk) begin
    checks++;
    if ({level, pulse, rel} !== {m_level, m_pulse, m_rel}) begin
      errors++;
      $display("FAIL outputs edge=%0d level/pulse/release got %b%b%b want %b%b%b",
               cyc, level, pulse, rel, m_level, m_pulse, m_rel);
    end
    checks++;
    if (pulse === 1'b1 && rel === 1'b1) begin
      errors++;
      $display("FAIL pulse_release_overlap edge=%0d got both high want at most one", cyc);
    end
    if (pulse === 1'b1) pulse_q.push_back(cyc);
    if (rel === 1'b1) rel_q.push_back(cyc);
    if (level === 1'b1 && prev_level !== 1'b1) rise_q.push_back(cyc);
    prev_level = level;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clearq();
    pulse_q.delete();
    rel_q.delete();
    rise_q.delete();
  endtask

  int k, p, e;

  initial begin
    // Reset state
    step(3);
    chk("reset_level", int'(level), 0);
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_release", int'(rel), 0);
    reset_n = 1'b1;
    step(3);

    // Clean press, repeat disabled
    clearq();
    raw = 1'b1; k = cyc + 1;
    step(40);
    chk("t1_pulse_count", pulse_q.size(), 1);
    chk("t1_pulse_edge", qat(pulse_q, 0), k + 6);
    chk("t1_level_rise_edge", qat(rise_q, 0), k + 6);
    raw = 1'b0; k = cyc + 1;
    step(12);
    chk("t1_release_count", rel_q.size(), 1);
    chk("t1_release_edge", qat(rel_q, 0), k + 6);

    // Bounce then stable high
    clearq();
    for (int i = 0; i < 12; i++) begin
      raw = ((i / 2) % 2 == 0);
      step(1);
    end
    chk("t2_pulses_in_bounce", pulse_q.size(), 0);
    raw = 1'b1; k = cyc + 1;
    step(15);
    chk("t2_pulse_count", pulse_q.size(), 1);
    chk("t2_pulse_edge", qat(pulse_q, 0), k + 6);
    raw = 1'b0;
    step(12);
    chk("t2_release_count", rel_q.size(), 1);

    // Auto-repeat
    clearq();
    en = 1'b1; raw = 1'b1; k = cyc + 1; p = k + 6;
    step(p + 54 - cyc);
    raw = 1'b0;
    step(15);
    chk("t3_pulse_count", pulse_q.size(), 6);
    chk("t3_press_edge", qat(pulse_q, 0), p);
    for (int i = 1; i < 6; i++) chk("t3_repeat_edge", qat(pulse_q, i), p + 12 + 8 * i);
    chk("t3_release_edge", qat(rel_q, 0), p + 61);

    // Release glitch while held
    clearq();
    raw = 1'b1; k = cyc + 1; p = k + 6;
    step(p + 2 - cyc);
    raw = 1'b0;
    step(2);
    raw = 1'b1;
    step(p + 30 - cyc);
    chk("t4_no_release", rel_q.size(), 0);
    chk("t4_level_held", int'(level), 1);
    raw = 1'b0;
    step(15);
    chk("t4_pulse_count", pulse_q.size(), 2);
    chk("t4_first_repeat_edge", qat(pulse_q, 1), p + 27);
    chk("t4_release_edge", qat(rel_q, 0), p + 37);

    // Asynchronous reset in the middle of repeating
    clearq();
    raw = 1'b1; k = cyc + 1; p = k + 6;
    step(p + 28 - cyc);
    chk("t5_pulse_before_reset", int'(pulse), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_level", int'(level), 0);
    chk("t5_async_pulse", int'(pulse), 0);
    chk("t5_async_release", int'(rel), 0);
    step(2);
    clearq();
    reset_n = 1'b1; e = cyc + 1;
    step(15);
    chk("t5_pulse_count", pulse_q.size(), 1);
    chk("t5_pulse_edge", qat(pulse_q, 0), e + 6);
    raw = 1'b0;
    step(12);

    // repeat_en dropped while repeating
    clearq();
    en = 1'b1; raw = 1'b1; k = cyc + 1; p = k + 6;
    step(p + 22 - cyc);
    en = 1'b0;
    step(40);
    chk("t6_pulse_count", pulse_q.size(), 2);
    chk("t6_repeat_edge", qat(pulse_q, 1), p + 20);
    chk("t6_level_held", int'(level), 1);
    raw = 1'b0; k = cyc + 1;
    step(12);
    chk("t6_release_count", rel_q.size(), 1);
    chk("t6_release_edge", qat(rel_q, 0), k + 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
